// File: rtl/regb_fifo_lvl.sv
// Register-based FIFO with fill level, almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and full-and-read pass-through.
module regb_fifo_lvl #(
  parameter int N      = 8,
  parameter int WIDTH  = 8,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 1,
  parameter int LW     = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] wdata,
  input  logic             shift_in,
  input  logic             shift_out,
  input  logic             clear_err,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full,
  output logic             almost_empty,
  output logic             almost_full,
  output logic [LW-1:0]    level,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [LW-1:0]    LVL_ZERO = {LW{1'b0}};
  localparam logic [LW-1:0]    LVL_ONE  = LW'(1);
  localparam logic [LW-1:0]    LVL_N    = LW'(N);
  localparam logic [LW-1:0]    LVL_AF   = LW'(AF_LVL);
  localparam logic [LW-1:0]    LVL_AE   = LW'(AE_LVL);
  localparam logic [WIDTH-1:0] DATA_ZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0] mem_r     [N];
  logic [WIDTH-1:0] shifted_s [N];
  logic [WIDTH-1:0] mem_nxt_s [N];
  logic [LW-1:0]    level_r;
  logic [LW-1:0]    level_nxt_s;
  logic [LW-1:0]    wr_idx_s;
  logic             push_ok_s;
  logic             pop_ok_s;
  logic             ovf_evt_s;
  logic             unf_evt_s;
  logic             empty_r;
  logic             full_r;
  logic             almost_empty_r;
  logic             almost_full_r;
  logic             overflow_r;
  logic             underflow_r;

  // Accepted operations, rejected-request events and next fill level.
  always_comb begin
    push_ok_s = shift_in & ((level_r != LVL_N) | shift_out);
    pop_ok_s  = shift_out & (level_r != LVL_ZERO);
    ovf_evt_s = shift_in & ~shift_out & (level_r == LVL_N);
    unf_evt_s = shift_out & (level_r == LVL_ZERO);
    case ({push_ok_s, pop_ok_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
    // On a simultaneous pop the write lands one slot lower, after the shift.
    if (pop_ok_s) begin
      wr_idx_s = level_r - LVL_ONE;
    end else begin
      wr_idx_s = level_r;
    end
  end

  // Next storage contents: optional shift toward the head, then the write.
  always_comb begin
    for (int i = 0; i < N - 1; i++) begin
      shifted_s[i] = pop_ok_s ? mem_r[i+1] : mem_r[i];
    end
    shifted_s[N-1] = mem_r[N-1];
    for (int i = 0; i < N; i++) begin
      if (push_ok_s && (LW'(i) == wr_idx_s)) begin
        mem_nxt_s[i] = wdata;
      end else begin
        mem_nxt_s[i] = shifted_s[i];
      end
    end
  end

  // Storage, level, registered status flags and sticky error flags.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= DATA_ZERO;
      end
      level_r        <= LVL_ZERO;
      empty_r        <= 1'b1;
      full_r         <= 1'b0;
      almost_empty_r <= 1'b1;
      almost_full_r  <= 1'b0;
      overflow_r     <= 1'b0;
      underflow_r    <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) begin
        mem_r[i] <= mem_nxt_s[i];
      end
      level_r        <= level_nxt_s;
      empty_r        <= (level_nxt_s == LVL_ZERO);
      full_r         <= (level_nxt_s == LVL_N);
      almost_empty_r <= (level_nxt_s <= LVL_AE);
      almost_full_r  <= (level_nxt_s >= LVL_AF);
      // A new error in the clearing cycle keeps the flag set.
      overflow_r     <= ovf_evt_s | (overflow_r & ~clear_err);
      underflow_r    <= unf_evt_s | (underflow_r & ~clear_err);
    end
  end

  assign rdata        = mem_r[0];
  assign level        = level_r;
  assign empty        = empty_r;
  assign full         = full_r;
  assign almost_empty = almost_empty_r;
  assign almost_full  = almost_full_r;
  assign overflow     = overflow_r;
  assign underflow    = underflow_r;

endmodule

// File: tb/tb_regb_fifo_lvl.sv
// Directed bench for regb_fifo_lvl (N=8 and N=2 builds) plus a short
// model-checked random phase on the N=8 build.
module tb_regb_fifo_lvl;

  logic       clk;
  logic       res_n;
  logic [7:0] wd, rd;
  logic       si, so, ce;
  logic       emp, ful, ae, af, ovf, unf;
  logic [3:0] lvl;

  logic [7:0] wd2, rd2;
  logic       si2, so2, ce2;
  logic       emp2, ful2, ae2, af2, ovf2, unf2;
  logic [1:0] lvl2;

  int n_assert;
  int n_fail;

  regb_fifo_lvl #(.N(8), .WIDTH(8), .AF_LVL(6), .AE_LVL(1)) dut (
    .clk(clk), .res_n(res_n), .wdata(wd), .shift_in(si), .shift_out(so),
    .clear_err(ce), .rdata(rd), .empty(emp), .full(ful),
    .almost_empty(ae), .almost_full(af), .level(lvl),
    .overflow(ovf), .underflow(unf)
  );

  regb_fifo_lvl #(.N(2), .WIDTH(8), .AF_LVL(2), .AE_LVL(0)) dut2 (
    .clk(clk), .res_n(res_n), .wdata(wd2), .shift_in(si2), .shift_out(so2),
    .clear_err(ce2), .rdata(rd2), .empty(emp2), .full(ful2),
    .almost_empty(ae2), .almost_full(af2), .level(lvl2),
    .overflow(ovf2), .underflow(unf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic i, input logic o, input logic c, input logic [7:0] d);
    si = i; so = o; ce = c; wd = d;
  endtask

  // Checks all status outputs of the N=8 instance: {emp,ful,ae,af,ovf,unf}.
  task automatic chk_st(input string tag, input logic [3:0] l, input logic [5:0] st);
    chk({tag, ".level"}, 32'(lvl), 32'(l));
    chk({tag, ".flags"}, 32'({emp, ful, ae, af, ovf, unf}), 32'(st));
  endtask

  logic [7:0] q[$];
  logic       m_ovf, m_unf;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    res_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    si2 = 1'b0; so2 = 1'b0; ce2 = 1'b0; wd2 = 8'h00;
    #22;
    chk("reset.rdata", 32'(rd), 32'h0);
    chk_st("reset", 4'd0, 6'b101000);
    res_n = 1'b1;

    // Test 1: three pushes, then drain.
    drive(1'b1, 1'b0, 1'b0, 8'h11); step();
    chk("t1.rdata1", 32'(rd), 32'h11);
    chk_st("t1.l1", 4'd1, 6'b001000);
    wd = 8'h22; step();
    chk_st("t1.l2", 4'd2, 6'b000000);
    wd = 8'h33; step();
    chk("t1.rdata3", 32'(rd), 32'h11);
    chk_st("t1.l3", 4'd3, 6'b000000);
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    chk("t1.pop1", 32'(rd), 32'h22);
    step();
    chk("t1.pop2", 32'(rd), 32'h33);
    step();
    chk_st("t1.drained", 4'd0, 6'b101000);

    // Test 2: fill to N, overflow, clear.
    for (int k = 1; k <= 8; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(k)); step();
      if (k == 5) chk_st("t2.l5", 4'd5, 6'b000000);
      if (k == 6) chk_st("t2.l6", 4'd6, 6'b000100);
    end
    chk_st("t2.full", 4'd8, 6'b010100);
    chk("t2.head", 32'(rd), 32'h01);
    wd = 8'hFF; step();
    chk_st("t2.ovf", 4'd8, 6'b010110);
    drive(1'b0, 1'b0, 1'b1, 8'h00); step();
    chk_st("t2.clr", 4'd8, 6'b010100);

    // Test 3: pass-through on a full FIFO, then drain in order.
    drive(1'b1, 1'b1, 1'b0, 8'hA5); step();
    chk_st("t3.pass", 4'd8, 6'b010100);
    chk("t3.rdata", 32'(rd), 32'h02);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    for (int k = 3; k <= 9; k++) begin
      step();
      chk($sformatf("t3.pop%0d", k), 32'(rd), (k == 9) ? 32'hA5 : 32'(k));
    end
    step();
    chk_st("t3.empty", 4'd0, 6'b101000);

    // Test 4: underflow, push+pop on empty, clear, clear-vs-new-error.
    step();
    chk_st("t4.unf", 4'd0, 6'b101001);
    drive(1'b1, 1'b1, 1'b0, 8'h3C); step();
    chk_st("t4.pushpop", 4'd1, 6'b001001);
    chk("t4.rdata", 32'(rd), 32'h3C);
    drive(1'b0, 1'b0, 1'b1, 8'h00); step();
    chk_st("t4.clr", 4'd1, 6'b001000);
    drive(1'b0, 1'b1, 1'b0, 8'h00); step();
    step();
    chk_st("t4.unf2", 4'd0, 6'b101001);
    drive(1'b0, 1'b1, 1'b1, 8'h00); step();
    chk_st("t4.newwins", 4'd0, 6'b101001);
    drive(1'b0, 1'b0, 1'b1, 8'h00); step();
    chk_st("t4.clr2", 4'd0, 6'b101000);

    // Test 5: asynchronous reset at level 5.
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h50 + 8'(k)); step();
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    chk_st("t5.l5", 4'd5, 6'b000000);
    #2 res_n = 1'b0;
    #1;
    chk("t5.rst.rdata", 32'(rd), 32'h0);
    chk_st("t5.rst", 4'd0, 6'b101000);
    #1 res_n = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 8'h77); step();
    chk("t5.rdata", 32'(rd), 32'h77);
    chk_st("t5.l1", 4'd1, 6'b001000);
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    // N=2 build: fill, overflow, pass-through, drain.
    si2 = 1'b1; wd2 = 8'hA1; step();
    chk("n2.l1", 32'({lvl2, emp2, ful2, ae2, af2}), {26'd0, 2'd1, 4'b0000});
    wd2 = 8'hB2; step();
    chk("n2.full", 32'({lvl2, emp2, ful2, ae2, af2}), {26'd0, 2'd2, 4'b0101});
    wd2 = 8'hC3; step();
    chk("n2.ovf", 32'({ovf2, unf2, lvl2}), 32'b1010);
    so2 = 1'b1; ce2 = 1'b1; step();
    chk("n2.pass", 32'({ovf2, lvl2, rd2}), {21'd0, 1'b0, 2'd2, 8'hB2});
    si2 = 1'b0; ce2 = 1'b0; step();
    chk("n2.pop", 32'({lvl2, rd2}), {22'd0, 2'd1, 8'hC3});
    step();
    chk("n2.empty", 32'({lvl2, emp2, ae2, unf2}), 32'b00110);
    so2 = 1'b0;

    // Random phase on the N=8 build against a queue model.
    q = {8'h77};
    m_ovf = 1'b0;
    m_unf = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      logic pi, po, pc, push_ok, pop_ok;
      logic [7:0] d;
      int L;
      pi = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 45);
      pc = ($urandom_range(0, 99) < 5);
      d  = 8'($urandom);
      drive(pi, po, pc, d);
      L = q.size();
      push_ok = pi && (L < 8 || po);
      pop_ok  = po && (L > 0);
      m_ovf = (pi && !po && L == 8) || (m_ovf && !pc);
      m_unf = (po && L == 0) || (m_unf && !pc);
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(d);
      step();
      chk_st("rnd", 4'(q.size()),
             {q.size() == 0, q.size() == 8, q.size() <= 1, q.size() >= 6, m_ovf, m_unf});
      if (q.size() > 0) chk("rnd.rdata", 32'(rd), 32'(q[0]));
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
